// File: rtl/xaui_rx_pkg.sv
// rtl/xaui_rx_pkg.sv - shared constants and state types for the XAUI receive link-state block
package xaui_rx_pkg;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam int LANES = 4;

  typedef enum logic [1:0] {LOS, DET, SYNC} lane_state_t;
  typedef enum logic [1:0] {ALOST, AWAIT, ALIGNED} align_state_t;
endpackage

// File: rtl/xaui_rx_sync_if.sv
// rtl/xaui_rx_sync_if.sv - MGT-facing rx bus, control enables and link status of one XAUI port
interface xaui_rx_sync_if;
  logic [63:0] mgt_rxdata;
  logic [7:0]  mgt_rxcharisk;
  logic [7:0]  mgt_rxcodevalid;
  logic [3:0]  mgt_rxsyncok;
  logic [3:0]  mgt_rxbufferr;
  logic        err_clr;
  logic [3:0]  mgt_rxencommaalign;
  logic        mgt_rxenchansync;
  logic        mgt_rx_rst;
  logic [3:0]  lane_sync;
  logic        link_up;
  logic [15:0] rx_err_count;

  modport master (
    output mgt_rxdata, mgt_rxcharisk, mgt_rxcodevalid, mgt_rxsyncok, mgt_rxbufferr, err_clr,
    input  mgt_rxencommaalign, mgt_rxenchansync, mgt_rx_rst, lane_sync, link_up, rx_err_count
  );

  modport slave (
    input  mgt_rxdata, mgt_rxcharisk, mgt_rxcodevalid, mgt_rxsyncok, mgt_rxbufferr, err_clr,
    output mgt_rxencommaalign, mgt_rxenchansync, mgt_rx_rst, lane_sync, link_up, rx_err_count
  );
endinterface

// File: rtl/xaui_lane_sync.sv
// rtl/xaui_lane_sync.sv - per-lane code-group sync FSM (LOS/DET/SYNC) on a registered 2-byte lane slice
module xaui_lane_sync
  import xaui_rx_pkg::*;
#(
  parameter int unsigned SYNC_COMMAS = 4,
  parameter int unsigned LOSS_ERRS   = 4,
  parameter int unsigned GOOD_RUN    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        force_los,
  input  logic [15:0] data,
  input  logic [1:0]  charisk,
  input  logic [1:0]  codevalid,
  output logic        lane_sync
);
  lane_state_t state;
  logic [7:0]  cnt, bad, good;
  logic        clean, comma;

  assign clean = &codevalid;
  assign comma = ((data[7:0] == K28_5) && charisk[0] && codevalid[0]) ||
                 ((data[15:8] == K28_5) && charisk[1] && codevalid[1]);

  // lane_sync only moves on transitions into/out of SYNC, so it is set in those branches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOS; cnt <= '0; bad <= '0; good <= '0; lane_sync <= 1'b0;
    end else if (force_los) begin
      state <= LOS; cnt <= '0; bad <= '0; good <= '0; lane_sync <= 1'b0;
    end else begin
      unique case (state)
        LOS: if (clean && comma) begin
          state <= DET; cnt <= 8'd1;
        end
        DET: if (!clean) begin
          state <= LOS; cnt <= '0;
        end else if (comma) begin
          if (cnt == 8'(SYNC_COMMAS - 1)) begin
            state <= SYNC; cnt <= '0; bad <= '0; good <= '0; lane_sync <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SYNC: if (!clean) begin
          good <= '0;
          if (bad == 8'(LOSS_ERRS - 1)) begin
            state <= LOS; bad <= '0; cnt <= '0; lane_sync <= 1'b0;
          end else begin
            bad <= bad + 8'd1;
          end
        end else if (good == 8'(GOOD_RUN - 1)) begin
          good <= '0;
          if (bad != 8'd0) bad <= bad - 8'd1;
        end else begin
          good <= good + 8'd1;
        end
        default: begin
          state <= LOS; cnt <= '0; bad <= '0; good <= '0; lane_sync <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/xaui_rx_sync.sv
// rtl/xaui_rx_sync.sv - XAUI rx link state: lane sync, ||A|| alignment, watchdog rx reset, error count
module xaui_rx_sync
  import xaui_rx_pkg::*;
#(
  parameter int unsigned SYNC_COMMAS    = 4,
  parameter int unsigned LOSS_ERRS      = 4,
  parameter int unsigned GOOD_RUN       = 4,
  parameter int unsigned ALIGN_COLS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RST_PULSE      = 8
) (
  input logic           xaui_clk,
  input logic           reset,
  xaui_rx_sync_if.slave bus
);
  logic [63:0]      r_data;
  logic [7:0]       r_charisk, r_codevalid;
  logic [3:0]       r_syncok, r_bufferr;
  logic [LANES-1:0] lane_sync_q, is_a0, is_a1;
  logic             all_sync, a_col, a_err, link_up_q, chansync_q, rst_pulse;
  align_state_t     astate;
  logic [7:0]       col, pulse_cnt;
  logic [1:0]       aerr;
  logic [19:0]      wd_cnt;
  logic [15:0]      err_cnt;
  logic [3:0]       nerr;
  logic [16:0]      err_sum;

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      r_data <= '0; r_charisk <= '0; r_codevalid <= '0; r_syncok <= '0; r_bufferr <= '0;
    end else begin
      r_data      <= bus.mgt_rxdata;
      r_charisk   <= bus.mgt_rxcharisk;
      r_codevalid <= bus.mgt_rxcodevalid;
      r_syncok    <= bus.mgt_rxsyncok;
      r_bufferr   <= bus.mgt_rxbufferr;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    xaui_lane_sync #(
      .SYNC_COMMAS(SYNC_COMMAS), .LOSS_ERRS(LOSS_ERRS), .GOOD_RUN(GOOD_RUN)
    ) u_lane (
      .clk(xaui_clk), .rst(reset), .force_los(rst_pulse),
      .data(r_data[16*l +: 16]), .charisk(r_charisk[2*l +: 2]),
      .codevalid(r_codevalid[2*l +: 2]), .lane_sync(lane_sync_q[l])
    );
  end

  always_comb begin
    is_a0 = '0;
    is_a1 = '0;
    for (int l = 0; l < LANES; l++) begin
      is_a0[l] = (r_data[16*l +: 8] == K28_3) && r_charisk[2*l];
      is_a1[l] = (r_data[16*l+8 +: 8] == K28_3) && r_charisk[2*l+1];
    end
  end

  assign all_sync = &lane_sync_q;
  assign a_col    = (&is_a0) || (&is_a1);
  assign a_err    = ((|is_a0) && !(&is_a0)) || ((|is_a1) && !(&is_a1));

  // Loss conditions override every state; ALOST itself falls straight through to AWAIT otherwise
  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      astate <= ALOST; col <= '0; aerr <= '0; link_up_q <= 1'b0; chansync_q <= 1'b0;
    end else begin
      chansync_q <= all_sync;
      if (rst_pulse || !all_sync || (|r_bufferr) || !(&r_syncok)) begin
        astate <= ALOST; col <= '0; aerr <= '0; link_up_q <= 1'b0;
      end else begin
        unique case (astate)
          ALOST: begin
            astate <= AWAIT; col <= '0;
          end
          AWAIT: if (a_err) begin
            col <= '0;
          end else if (a_col) begin
            if (col == 8'(ALIGN_COLS - 1)) begin
              astate <= ALIGNED; col <= '0; aerr <= '0; link_up_q <= 1'b1;
            end else begin
              col <= col + 8'd1;
            end
          end
          ALIGNED: if (a_err) begin
            col <= '0;
            if (aerr == 2'd3) begin
              astate <= ALOST; aerr <= '0; link_up_q <= 1'b0;
            end else begin
              aerr <= aerr + 2'd1;
            end
          end else if (a_col) begin
            if (col == 8'(ALIGN_COLS - 1)) begin
              col <= '0; aerr <= '0;
            end else begin
              col <= col + 8'd1;
            end
          end
          default: begin
            astate <= ALOST; col <= '0; aerr <= '0; link_up_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0; pulse_cnt <= '0; rst_pulse <= 1'b0;
    end else if (rst_pulse) begin
      if (pulse_cnt == 8'(RST_PULSE - 1)) begin
        rst_pulse <= 1'b0; pulse_cnt <= '0;
      end else begin
        pulse_cnt <= pulse_cnt + 8'd1;
      end
    end else if (link_up_q) begin
      wd_cnt <= '0;
    end else if (wd_cnt == 20'(TIMEOUT_CYCLES - 1)) begin
      rst_pulse <= 1'b1; wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 20'd1;
    end
  end

  // Error tally uses the raw inputs so err_clr drops exactly the errors of its own cycle
  always_comb begin
    nerr = '0;
    for (int i = 0; i < 8; i++) nerr = nerr + {3'b000, ~bus.mgt_rxcodevalid[i]};
    err_sum = {1'b0, err_cnt} + {13'd0, nerr};
  end

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset)            err_cnt <= '0;
    else if (bus.err_clr) err_cnt <= '0;
    else if (err_sum[16]) err_cnt <= 16'hFFFF;
    else                  err_cnt <= err_sum[15:0];
  end

  assign bus.lane_sync          = lane_sync_q;
  assign bus.mgt_rxencommaalign = ~lane_sync_q;
  assign bus.mgt_rxenchansync   = chansync_q;
  assign bus.link_up            = link_up_q;
  assign bus.mgt_rx_rst         = rst_pulse;
  assign bus.rx_err_count       = err_cnt;
endmodule

// File: tb/tb_xaui_rx_sync.sv
// tb/tb_xaui_rx_sync.sv - directed self-checking bench for xaui_rx_sync
module tb_xaui_rx_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [63:0] IDLE  = {4{16'h1CBC}};
  localparam logic [63:0] ACOL  = {4{16'h7C7C}};
  localparam logic [63:0] AERR3 = {16'h1C1C, 16'h7C7C, 16'h7C7C, 16'h7C7C};

  xaui_rx_sync_if bus();

  xaui_rx_sync #(.TIMEOUT_CYCLES(100)) dut (
    .xaui_clk(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic [7:0] v);
    bus.mgt_rxdata = d;
    bus.mgt_rxcharisk = k;
    bus.mgt_rxcodevalid = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mgt_rxsyncok = 4'hF;
    bus.mgt_rxbufferr = 4'h0;
    bus.err_clr = 1'b0;
    drive(IDLE, 8'h55, 8'hFF);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic bring_up();
    do_reset();
    for (int i = 1; i <= 6; i++) begin drive(IDLE, 8'h55, 8'hFF); tick(); end
    for (int i = 7; i <= 10; i++) begin drive(ACOL, 8'hFF, 8'hFF); tick(); end
    drive(IDLE, 8'h55, 8'hFF);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    vectors++;
    if ({bus.lane_sync, bus.mgt_rxencommaalign, bus.mgt_rxenchansync, bus.link_up, bus.mgt_rx_rst} !== {4'h0, 4'hF, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_status got ls=%h ca=%h cs=%b lu=%b rr=%b", bus.lane_sync, bus.mgt_rxencommaalign,
               bus.mgt_rxenchansync, bus.link_up, bus.mgt_rx_rst);
    end
    vectors++;
    if (bus.rx_err_count !== 16'h0) begin
      miscompares++; $display("FAIL reset_err_count got %h exp 0000", bus.rx_err_count);
    end
  endtask

  task automatic test_link();
    do_reset();
    for (int i = 1; i <= 4; i++) begin drive(IDLE, 8'h55, 8'hFF); tick(); end
    vectors++;
    if (bus.lane_sync !== 4'h0) begin
      miscompares++; $display("FAIL sync_early got %h exp 0", bus.lane_sync);
    end
    tick();
    vectors++;
    if (bus.lane_sync !== 4'hF) begin
      miscompares++; $display("FAIL lane_sync got %h exp f", bus.lane_sync);
    end
    vectors++;
    if (bus.mgt_rxencommaalign !== 4'h0) begin
      miscompares++; $display("FAIL comma_align got %h exp 0", bus.mgt_rxencommaalign);
    end
    tick();
    vectors++;
    if (bus.mgt_rxenchansync !== 1'b1) begin
      miscompares++; $display("FAIL chansync got %b exp 1", bus.mgt_rxenchansync);
    end
    for (int i = 7; i <= 10; i++) begin drive(ACOL, 8'hFF, 8'hFF); tick(); end
    vectors++;
    if (bus.link_up !== 1'b0) begin
      miscompares++; $display("FAIL link_early got %b exp 0", bus.link_up);
    end
    drive(IDLE, 8'h55, 8'hFF);
    tick();
    vectors++;
    if (bus.link_up !== 1'b1) begin
      miscompares++; $display("FAIL link_up got %b exp 1", bus.link_up);
    end
    vectors++;
    if (bus.rx_err_count !== 16'h0) begin
      miscompares++; $display("FAIL link_err_count got %h exp 0000", bus.rx_err_count);
    end
  endtask

  task automatic test_lane_loss();
    bring_up();
    for (int k = 0; k < 4; k++) begin
      drive(IDLE, 8'h55, 8'hFC);
      tick();
      drive(IDLE, 8'h55, 8'hFF);
      tick();
      tick();
      if (k == 2) begin
        vectors++;
        if (bus.lane_sync !== 4'hF) begin
          miscompares++; $display("FAIL loss_three_bad got %h exp f", bus.lane_sync);
        end
      end
    end
    vectors++;
    if (bus.lane_sync !== 4'hE) begin
      miscompares++; $display("FAIL loss_lane_sync got %h exp e", bus.lane_sync);
    end
    vectors++;
    if (bus.mgt_rxencommaalign !== 4'h1) begin
      miscompares++; $display("FAIL loss_comma_align got %h exp 1", bus.mgt_rxencommaalign);
    end
    vectors++;
    if (bus.link_up !== 1'b0) begin
      miscompares++; $display("FAIL loss_link_up got %b exp 0", bus.link_up);
    end
    vectors++;
    if (bus.rx_err_count !== 16'd8) begin
      miscompares++; $display("FAIL loss_err_count got %0d exp 8", bus.rx_err_count);
    end
  endtask

  task automatic test_align_err();
    bring_up();
    for (int i = 0; i < 4; i++) begin drive(AERR3, 8'hFF, 8'hFF); tick(); end
    vectors++;
    if (bus.link_up !== 1'b1) begin
      miscompares++; $display("FAIL aerr_three got %b exp 1", bus.link_up);
    end
    drive(IDLE, 8'h55, 8'hFF);
    tick();
    vectors++;
    if (bus.link_up !== 1'b0) begin
      miscompares++; $display("FAIL aerr_four got %b exp 0", bus.link_up);
    end
    vectors++;
    if (bus.lane_sync !== 4'hF) begin
      miscompares++; $display("FAIL aerr_lane_sync got %h exp f", bus.lane_sync);
    end
  endtask

  task automatic test_bufferr();
    bring_up();
    bus.mgt_rxbufferr = 4'b0100;
    tick();
    bus.mgt_rxbufferr = 4'b0000;
    vectors++;
    if (bus.link_up !== 1'b1) begin
      miscompares++; $display("FAIL bufferr_hold got %b exp 1", bus.link_up);
    end
    tick();
    vectors++;
    if (bus.link_up !== 1'b0) begin
      miscompares++; $display("FAIL bufferr_drop got %b exp 0", bus.link_up);
    end
  endtask

  task automatic test_watchdog();
    logic exp;
    do_reset();
    drive(64'h0, 8'h00, 8'hFF);
    for (int i = 1; i <= 210; i++) begin
      tick();
      exp = ((i % 108) >= 100);
      vectors++;
      if (bus.mgt_rx_rst !== exp) begin
        miscompares++; $display("FAIL watchdog cycle %0d got %b exp %b", i, bus.mgt_rx_rst, exp);
      end
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.mgt_rx_rst !== 1'b0) begin
      miscompares++; $display("FAIL watchdog_async_reset got %b exp 0", bus.mgt_rx_rst);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_err_count();
    do_reset();
    drive(64'h0, 8'h00, 8'h00);
    for (int n = 1; n <= 8193; n++) begin
      tick();
      if (n == 8191) begin
        vectors++;
        if (bus.rx_err_count !== 16'd65528) begin
          miscompares++; $display("FAIL err_near_sat got %0d exp 65528", bus.rx_err_count);
        end
      end
      if (n >= 8192) begin
        vectors++;
        if (bus.rx_err_count !== 16'hFFFF) begin
          miscompares++; $display("FAIL err_sat n=%0d got %h exp ffff", n, bus.rx_err_count);
        end
      end
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    vectors++;
    if (bus.rx_err_count !== 16'h0) begin
      miscompares++; $display("FAIL err_clr got %h exp 0000", bus.rx_err_count);
    end
    tick();
    vectors++;
    if (bus.rx_err_count !== 16'd8) begin
      miscompares++; $display("FAIL err_after_clr got %0d exp 8", bus.rx_err_count);
    end
  endtask

  initial begin
    bus.mgt_rxsyncok = 4'hF;
    bus.mgt_rxbufferr = 4'h0;
    bus.err_clr = 1'b0;
    drive(IDLE, 8'h55, 8'hFF);
    test_reset();
    test_link();
    test_lane_loss();
    test_align_err();
    test_bufferr();
    test_watchdog();
    test_err_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/xaui_rx_sync.md
Name: xaui_rx_sync

Overview:
- Per-port XAUI receive link-state block, placed directly downstream of the MGT infrastructure block; one instance per enabled XAUI port.
- Consumes a port's 64-bit rx bus: 4 lanes x 2 bytes per cycle.
- Runs per-lane code-group sync and 4-lane alignment (||A||) state machines.
- Drives comma-align and channel-bond enables back to the MGT, reports link_up, and auto-pulses the MGT rx reset if the link does not come up.

Parameters:
- SYNC_COMMAS, 4: consecutive comma-bearing clean cycles required for lane sync.
- LOSS_ERRS, 4: net bad-cycle tally that drops lane sync.
- GOOD_RUN, 4: consecutive clean cycles that decrement the bad tally.
- ALIGN_COLS, 4: consecutive aligned ||A|| columns required for alignment.
- TIMEOUT_CYCLES, 1000000: cycles without link_up before an rx reset pulse.
- RST_PULSE, 8: width of the mgt_rx_rst pulse in cycles.

Ports:
- xaui_clk  in  1  port clock; all logic is synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- mgt_rxdata  in  64  lane L = bits [16L+15:16L], low byte first.
- mgt_rxcharisk  in  8  bit 2L+b flags byte b of lane L as a K char.
- mgt_rxcodevalid  in  8  1 = valid code group, same bit mapping.
- mgt_rxsyncok  in  4  MGT channel-bond done, per lane.
- mgt_rxbufferr  in  4  MGT elastic buffer error, per lane.
- err_clr  in  1  clears rx_err_count.
- mgt_rxencommaalign  out  4  per-lane comma-align enable.
- mgt_rxenchansync  out  1  channel-bond enable.
- mgt_rx_rst  out  1  MGT rx reset request.
- lane_sync  out  4  per-lane sync status.
- link_up  out  1  alignment achieved.
- rx_err_count  out  16  saturating count of invalid code groups.

Behaviour:
- Char classes:
  - Comma: K28.5 (0xBC) with charisk=1 and codevalid=1.
  - A: K28.3 (0x7C) with charisk=1.
  - Bad lane-cycle: either of the lane's 2 bytes has codevalid=0.
- Lane FSM (per lane): LOS, DET, SYNC.
  - LOS: enter DET with cnt=1 on a clean cycle containing a comma.
  - DET: a bad cycle returns to LOS. A clean comma cycle does cnt++; when cnt reaches SYNC_COMMAS, go to SYNC. Other clean cycles hold.
  - SYNC: a bad cycle does bad++ and zeroes the good run. A clean cycle does good++; when good reaches GOOD_RUN, set good=0 and decrement bad if bad>0. bad reaching LOSS_ERRS goes to LOS and clears the counters.
  - lane_sync[L] = (state==SYNC), registered.
  - mgt_rxencommaalign[L] = ~lane_sync[L].
- Align FSM: ALOST, AWAIT, ALIGNED.
  - all_sync = &lane_sync. mgt_rxenchansync = all_sync, registered.
  - A-column: for byte position b, all 4 lanes carry A.
  - A-error: A appears in some lanes but not all at the same b in that cycle.
  - ALOST -> AWAIT when all_sync and &mgt_rxsyncok.
  - AWAIT: an A-column does col++; reaching ALIGN_COLS goes to ALIGNED. An A-error sets col=0.
  - ALIGNED: A-error does aerr++; ALIGN_COLS consecutive A-columns clear aerr; aerr reaching 4 goes to ALOST.
  - From any state, go to ALOST in the next cycle on any of: !all_sync, any mgt_rxbufferr bit, or any mgt_rxsyncok bit low.
  - link_up = (state==ALIGNED).
- Timing and latency:
  - Inputs are registered once before decode.
  - Status outputs change 2 cycles after the qualifying input cycle.
- Watchdog:
  - 20-bit counter increments while !link_up and mgt_rx_rst is low, and clears on link_up.
  - At TIMEOUT_CYCLES, mgt_rx_rst goes high for exactly RST_PULSE cycles.
  - All lane and align FSMs are forced to LOS/ALOST during the pulse. The counter restarts after the pulse.
- rx_err_count:
  - Each cycle adds the number of codevalid=0 bytes (0..8).
  - Saturates at 0xFFFF.
  - err_clr has priority: the count is 0 in the cycle after err_clr, and that cycle's errors are dropped.
- Reset values: lane_sync=0, mgt_rxencommaalign=4'hF, mgt_rxenchansync=0, link_up=0, mgt_rx_rst=0, rx_err_count=0. All FSMs reset to LOS/ALOST with counters at 0.
- Reset mid-operation clears everything asynchronously, including an in-progress rst pulse.

Decomposition:
- Package xaui_rx_pkg holds:
  - constants K28_5=8'hBC, K28_3=8'h7C, LANES=4;
  - typedefs lane_state_t {LOS,DET,SYNC} and align_state_t {ALOST,AWAIT,ALIGNED}.
- Sub-module xaui_lane_sync (one lane FSM, 16-bit slice in, lane_sync out), instantiated 4x.
- Top level holds the align FSM, the watchdog and the error counter.

Test Plan:
- Idle/comma stream on all lanes (0xBC low byte, 0x1C high, charisk=2'b01 per lane), rxsyncok=F -> lane_sync=F and mgt_rxencommaalign=0 2 cycles after the 4th comma cycle; mgt_rxenchansync=1.
- Then 4 cycles of 0x7C7C on every lane, charisk=FF -> link_up=1 2 cycles after the 4th column.
- Linked, then codevalid[1:0]=0 on lane 0 for 4 isolated cycles, each followed by 2 clean cycles -> lane_sync[0]=0, link_up=0, mgt_rxencommaalign=4'b0001, rx_err_count=8.
- Linked, then A on lanes 0-2 only for 4 cycles -> link_up drops; a single mgt_rxbufferr=4'b0100 pulse also drops link_up the next cycle.
- TIMEOUT_CYCLES=100, no commas -> mgt_rx_rst high on cycles 100-107 only; repeats every 108 cycles.
- rx_err_count preloaded near 0xFFFF with 8 errors/cycle -> holds at 0xFFFF; err_clr asserted concurrently with errors -> reads 0 the next cycle.
